// File: rtl/lsu.sv
// Load/store unit for the milano RV32IM core: one memory access at a time over a req/gnt/rvalid
// data bus, with byte-lane steering on stores and shift/extend on loads.
package milano_pkg;
  typedef enum logic [3:0] {
    LSU_NONE, LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW
  } lsu_opt_e;
endpackage

module lsu #(
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  milano_pkg::lsu_opt_e  lsu_operate_i,
  input  logic [31:0]           lsu_addr_i,
  input  logic [31:0]           lsu_wdata_i,
  input  logic [4:0]            lsu_rd_addr_i,
  output logic                  lsu_busy_o,
  output logic [4:0]            lsu_rd_addr_o,
  output logic                  lsu_rd_wr_en_o,
  output logic [31:0]           lsu_rdata_o,
  output logic                  lsu_done_o,
  output logic                  lsu_err_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [31:0]           data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  input  logic                  data_err_i
);
  import milano_pkg::*;

  typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRvalid} state_e;

  state_e      state_q, state_d;
  lsu_opt_e    op_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [4:0]  rd_addr_q;
  logic        we_q, err_q;

  logic        is_half_in, is_word_in, misaligned_in, accept, misalign_err;
  logic [31:0] addr_in;
  logic        resp, load_wr;
  logic [3:0]  be;
  logic [31:0] wdata_lanes, rshift, load_ext;

  always_comb begin
    is_half_in    = lsu_operate_i inside {LSU_LH, LSU_LHU, LSU_SH};
    is_word_in    = lsu_operate_i inside {LSU_LW, LSU_SW};
    misaligned_in = (is_half_in & lsu_addr_i[0]) | (is_word_in & (|lsu_addr_i[1:0]));
    // Natural alignment is forced unconditionally; misaligned accesses never reach the bus when
    // checking is enabled, so this only matters with MISALIGN_CHECK=0.
    addr_in = lsu_addr_i;
    if (is_word_in) begin
      addr_in[1:0] = 2'b00;
    end else if (is_half_in) begin
      addr_in[0] = 1'b0;
    end
  end

  assign accept       = (state_q == StIdle) && lsu_req_i && (lsu_operate_i != LSU_NONE);
  assign misalign_err = accept && misaligned_in && MISALIGN_CHECK;
  assign resp         = (state_q == StWaitRvalid) && data_rvalid_i;
  assign load_wr      = resp && !data_err_i && !we_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:       if (accept && !misalign_err) state_d = StWaitGnt;
      StWaitGnt:    if (data_gnt_i) state_d = StWaitRvalid;
      StWaitRvalid: if (data_rvalid_i) state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_comb begin
    be          = 4'b0000;
    wdata_lanes = 32'h0;
    case (op_q)
      LSU_LB, LSU_LBU, LSU_SB: be = 4'b0001 << addr_q[1:0];
      LSU_LH, LSU_LHU, LSU_SH: be = 4'b0011 << {addr_q[1], 1'b0};
      LSU_LW, LSU_SW:          be = 4'b1111;
      default:                 be = 4'b0000;
    endcase
    case (op_q)
      LSU_SB:  wdata_lanes = {4{wdata_q[7:0]}};
      LSU_SH:  wdata_lanes = {2{wdata_q[15:0]}};
      LSU_SW:  wdata_lanes = wdata_q;
      default: wdata_lanes = 32'h0;
    endcase
  end

  always_comb begin
    rshift   = data_rdata_i >> {addr_q[1:0], 3'b000};
    load_ext = 32'h0;
    case (op_q)
      LSU_LB:  load_ext = {{24{rshift[7]}}, rshift[7:0]};
      LSU_LBU: load_ext = {24'h0, rshift[7:0]};
      LSU_LH:  load_ext = {{16{rshift[15]}}, rshift[15:0]};
      LSU_LHU: load_ext = {16'h0, rshift[15:0]};
      LSU_LW:  load_ext = rshift;
      default: load_ext = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      op_q      <= LSU_NONE;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rd_addr_q <= 5'h0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      err_q   <= misalign_err;
      if (accept) begin
        op_q      <= lsu_operate_i;
        addr_q    <= addr_in;
        wdata_q   <= lsu_wdata_i;
        rd_addr_q <= lsu_rd_addr_i;
        we_q      <= lsu_we_i;
      end
      if (load_wr) rdata_q <= load_ext;
    end
  end

  assign lsu_busy_o     = (state_q != StIdle);
  assign lsu_rd_addr_o  = rd_addr_q;
  assign lsu_rd_wr_en_o = load_wr;
  // Response data is forwarded combinationally so write-back lands in the rvalid cycle.
  assign lsu_rdata_o    = load_wr ? load_ext : rdata_q;
  assign lsu_done_o     = resp;
  assign lsu_err_o      = err_q | (resp & data_err_i);

  assign data_req_o   = (state_q == StWaitGnt);
  assign data_addr_o  = data_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
  assign data_we_o    = data_req_o & we_q;
  assign data_be_o    = data_req_o ? be : 4'b0000;
  assign data_wdata_o = data_req_o ? wdata_lanes : 32'h0;
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses checked against a
// byte-level reference model of the bus and register-file effects.
module tb_lsu;
  import milano_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        lsu_req, lsu_we;
  lsu_opt_e    lsu_op;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [4:0]  lsu_rd;
  logic        lsu_busy, lsu_rd_wr_en, lsu_done, lsu_err;
  logic [4:0]  lsu_rd_addr;
  logic [31:0] lsu_rdata;
  logic        data_req, data_gnt, data_we, data_rvalid, data_err;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_be;

  lsu #(.MISALIGN_CHECK(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_operate_i(lsu_op), .lsu_addr_i(lsu_addr),
    .lsu_wdata_i(lsu_wdata), .lsu_rd_addr_i(lsu_rd),
    .lsu_busy_o(lsu_busy), .lsu_rd_addr_o(lsu_rd_addr), .lsu_rd_wr_en_o(lsu_rd_wr_en),
    .lsu_rdata_o(lsu_rdata), .lsu_done_o(lsu_done), .lsu_err_o(lsu_err),
    .data_req_o(data_req), .data_gnt_i(data_gnt), .data_addr_o(data_addr), .data_we_o(data_we),
    .data_be_o(data_be), .data_wdata_o(data_wdata), .data_rvalid_i(data_rvalid),
    .data_rdata_i(data_rdata), .data_err_i(data_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Observations gathered by run_access; the tests compare them against expectations.
  int          obs_req_cycles, obs_busy, obs_done, obs_wr, obs_err, obs_wr_cyc;
  bit          obs_stable, obs_we;
  logic [31:0] obs_addr, obs_wdata, obs_rdata, obs_hold;
  logic [3:0]  obs_be;
  logic [4:0]  obs_rd;
  logic [31:0] exp_hold;

  function automatic int nbytes(lsu_opt_e op);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: return 1;
      LSU_LH, LSU_LHU, LSU_SH: return 2;
      default:                 return 4;
    endcase
  endfunction

  function automatic bit is_store(lsu_opt_e op);
    return op inside {LSU_SB, LSU_SH, LSU_SW};
  endfunction

  function automatic bit misaligned(lsu_opt_e op, logic [31:0] addr);
    return (int'(addr % 4) % nbytes(op)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(lsu_opt_e op, logic [31:0] addr);
    logic [7:0] m;
    m = ((8'd1 << nbytes(op)) - 8'd1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_store_data(lsu_opt_e op, logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(op);
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
    return is_store(op) ? r : 32'h0;
  endfunction

  function automatic logic [31:0] ref_load(lsu_opt_e op, logic [31:0] addr, logic [31:0] rd);
    logic [63:0] v;
    int n, off;
    n = nbytes(op);
    off = int'(addr % 4);
    v = 64'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = rd[8*(off+k) +: 8];
    if ((op == LSU_LB || op == LSU_LH) && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v[31:0];
  endfunction

  task automatic run_access(input lsu_opt_e op, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                            input logic [31:0] rdata, input logic berr);
    int  req_cnt, since_gnt;
    bit  granted, responded;
    obs_req_cycles = 0; obs_busy = 0; obs_done = 0; obs_wr = 0; obs_err = 0; obs_wr_cyc = -1;
    obs_stable = 1'b1; obs_we = 1'b0; obs_addr = '0; obs_wdata = '0; obs_be = '0;
    obs_rdata = '0; obs_rd = '0;
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = is_store(op); lsu_op = op; lsu_addr = addr; lsu_wdata = wd;
    lsu_rd = rd;
    @(negedge clk);
    lsu_req = 1'b0; lsu_op = LSU_NONE; lsu_addr = $urandom; lsu_wdata = $urandom;
    lsu_rd = 5'($urandom);
    granted = 1'b0; responded = 1'b0; req_cnt = 0; since_gnt = 0;
    for (int cyc = 1; cyc <= gnt_dly + rv_dly + 5; cyc++) begin
      data_gnt    = data_req && (req_cnt >= gnt_dly);
      data_rvalid = granted && !responded && (since_gnt >= rv_dly);
      data_rdata  = data_rvalid ? rdata : $urandom;
      data_err    = data_rvalid ? berr : 1'($urandom);
      #1;
      if (lsu_busy) obs_busy++;
      if (data_req) begin
        if (obs_req_cycles == 0) begin
          obs_addr = data_addr; obs_be = data_be; obs_we = data_we; obs_wdata = data_wdata;
        end else if (data_addr !== obs_addr || data_be !== obs_be || data_we !== obs_we ||
                     data_wdata !== obs_wdata) begin
          obs_stable = 1'b0;
        end
        obs_req_cycles++;
      end
      if (lsu_done) obs_done++;
      if (lsu_err) obs_err++;
      if (lsu_rd_wr_en) begin
        obs_wr++; obs_rdata = lsu_rdata; obs_rd = lsu_rd_addr; obs_wr_cyc = cyc;
      end
      if (data_rvalid) responded = 1'b1;
      if (granted) since_gnt++;
      if (data_gnt) granted = 1'b1;
      if (data_req) req_cnt++;
      @(negedge clk);
    end
    data_gnt = 1'b0; data_rvalid = 1'b0; data_err = 1'b0;
    obs_hold = lsu_rdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    n_cmp++; if ({lsu_busy, lsu_rd_wr_en, lsu_done, lsu_err} !== 4'b0) begin n_bad++;
      $display("FAIL reset_flags: got %b want 0000", {lsu_busy, lsu_rd_wr_en, lsu_done, lsu_err}); end
    n_cmp++; if ({lsu_rd_addr, lsu_rdata} !== 37'h0) begin n_bad++;
      $display("FAIL reset_rd: got %h/%h want 0", lsu_rd_addr, lsu_rdata); end
    n_cmp++; if ({data_req, data_we, data_be, data_addr, data_wdata} !== 70'h0) begin n_bad++;
      $display("FAIL reset_bus: got req=%b addr=%h be=%b want 0", data_req, data_addr, data_be); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_hold = 32'h0;
  endtask

  task automatic test_load_word();
    run_access(LSU_LW, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF, 1'b0);
    n_cmp++; if (obs_addr !== 32'h100 || obs_be !== 4'b1111) begin n_bad++;
      $display("FAIL lw_bus: got addr=%h be=%b want 00000100 1111", obs_addr, obs_be); end
    n_cmp++; if (obs_wr !== 1 || obs_rdata !== 32'hDEADBEEF || obs_rd !== 5'd5) begin n_bad++;
      $display("FAIL lw_wb: got wr=%0d data=%h rd=%0d want 1 deadbeef 5", obs_wr, obs_rdata, obs_rd); end
    n_cmp++; if (obs_busy !== 2 || obs_wr_cyc !== 2) begin n_bad++;
      $display("FAIL lw_latency: got busy=%0d wbcyc=%0d want 2 2", obs_busy, obs_wr_cyc); end
    n_cmp++; if (obs_hold !== 32'hDEADBEEF) begin n_bad++;
      $display("FAIL lw_hold: got %h want deadbeef", obs_hold); end
  endtask

  task automatic test_load_byte();
    run_access(LSU_LB, 32'h203, 32'h0, 5'd9, 1, 1, 32'h80112233, 1'b0);
    n_cmp++; if (obs_be !== 4'b1000 || obs_addr !== 32'h200) begin n_bad++;
      $display("FAIL lb_bus: got addr=%h be=%b want 00000200 1000", obs_addr, obs_be); end
    n_cmp++; if (obs_rdata !== 32'hFFFFFF80 || obs_wr !== 1) begin n_bad++;
      $display("FAIL lb_sext: got %h wr=%0d want ffffff80 1", obs_rdata, obs_wr); end
    run_access(LSU_LBU, 32'h203, 32'h0, 5'd9, 0, 2, 32'h80112233, 1'b0);
    n_cmp++; if (obs_rdata !== 32'h00000080 || obs_wr !== 1) begin n_bad++;
      $display("FAIL lbu_zext: got %h wr=%0d want 00000080 1", obs_rdata, obs_wr); end
  endtask

  task automatic test_store_half_stall();
    run_access(LSU_SH, 32'h302, 32'h0000ABCD, 5'd3, 3, 0, 32'h0, 1'b0);
    n_cmp++; if (obs_req_cycles !== 4 || !obs_stable) begin n_bad++;
      $display("FAIL sh_stall: got reqcyc=%0d stable=%b want 4 1", obs_req_cycles, obs_stable); end
    n_cmp++; if (obs_addr !== 32'h300 || obs_be !== 4'b1100 || obs_we !== 1'b1) begin n_bad++;
      $display("FAIL sh_bus: got addr=%h be=%b we=%b want 00000300 1100 1", obs_addr, obs_be, obs_we); end
    n_cmp++; if (obs_wdata !== 32'hABCDABCD) begin n_bad++;
      $display("FAIL sh_wdata: got %h want abcdabcd", obs_wdata); end
    n_cmp++; if (obs_done !== 1 || obs_wr !== 0 || obs_err !== 0) begin n_bad++;
      $display("FAIL sh_done: got done=%0d wr=%0d err=%0d want 1 0 0", obs_done, obs_wr, obs_err); end
  endtask

  task automatic test_misaligned();
    run_access(LSU_LW, 32'h101, 32'h0, 5'd4, 0, 0, 32'h12345678, 1'b0);
    n_cmp++; if (obs_req_cycles !== 0 || obs_busy !== 0) begin n_bad++;
      $display("FAIL mis_nobus: got reqcyc=%0d busy=%0d want 0 0", obs_req_cycles, obs_busy); end
    n_cmp++; if (obs_err !== 1 || obs_wr !== 0) begin n_bad++;
      $display("FAIL mis_err: got err=%0d wr=%0d want 1 0", obs_err, obs_wr); end
  endtask

  task automatic test_bus_error();
    run_access(LSU_LH, 32'h400, 32'h0, 5'd6, 0, 1, 32'h5555AAAA, 1'b1);
    n_cmp++; if (obs_err !== 1 || obs_done !== 1 || obs_wr !== 0) begin n_bad++;
      $display("FAIL berr: got err=%0d done=%0d wr=%0d want 1 1 0", obs_err, obs_done, obs_wr); end
    n_cmp++; if (obs_hold !== 32'h00000080) begin n_bad++;
      $display("FAIL berr_hold: got %h want 00000080", obs_hold); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_op = LSU_LW; lsu_addr = 32'h500; lsu_rd = 5'd7;
    @(negedge clk);
    lsu_req = 1'b0; lsu_op = LSU_NONE; data_gnt = 1'b1;
    @(negedge clk);
    data_gnt = 1'b0;
    n_cmp++; if (lsu_busy !== 1'b1 || data_req !== 1'b0) begin n_bad++;
      $display("FAIL mid_state: got busy=%b req=%b want 1 0", lsu_busy, data_req); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({lsu_busy, lsu_done, lsu_err, lsu_rd_wr_en, data_req, lsu_rdata, lsu_rd_addr} !== 42'h0)
      begin n_bad++; $display("FAIL mid_reset: got busy=%b rdata=%h rd=%0d want 0", lsu_busy,
        lsu_rdata, lsu_rd_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    data_rvalid = 1'b1; data_rdata = 32'hFFFF0000; data_err = 1'b0;
    #1;
    n_cmp++; if ({lsu_done, lsu_rd_wr_en, lsu_err, lsu_busy} !== 4'b0) begin n_bad++;
      $display("FAIL late_rvalid: got done=%b wr=%b err=%b busy=%b want 0", lsu_done,
        lsu_rd_wr_en, lsu_err, lsu_busy); end
    @(negedge clk);
    data_rvalid = 1'b0;
    exp_hold = 32'h0;
    run_access(LSU_SB, 32'h601, 32'h0000005A, 5'd8, 0, 0, 32'h0, 1'b0);
    n_cmp++; if (obs_be !== 4'b0010 || obs_wdata !== 32'h5A5A5A5A || obs_addr !== 32'h600) begin
      n_bad++; $display("FAIL sb_after_rst: got addr=%h be=%b wd=%h want 00000600 0010 5a5a5a5a",
        obs_addr, obs_be, obs_wdata); end
    n_cmp++; if (obs_done !== 1 || obs_wr !== 0 || obs_hold !== 32'h0) begin n_bad++;
      $display("FAIL sb_done: got done=%0d wr=%0d hold=%h want 1 0 0", obs_done, obs_wr, obs_hold); end
  endtask

  task automatic test_random();
    lsu_opt_e    op;
    logic [31:0] addr, wd, rdata, exp_ld;
    logic [4:0]  rd;
    logic        berr;
    int          gd;
    for (int i = 0; i < 60; i++) begin
      op    = lsu_opt_e'($urandom_range(1, 8));
      addr  = $urandom;
      wd    = $urandom;
      rdata = $urandom;
      rd    = 5'($urandom);
      berr  = ($urandom_range(0, 9) == 0);
      gd    = $urandom_range(0, 3);
      run_access(op, addr, wd, rd, gd, $urandom_range(0, 3), rdata, berr);
      if (misaligned(op, addr)) begin
        n_cmp++; if (obs_req_cycles !== 0 || obs_err !== 1 || obs_done !== 0 || obs_wr !== 0) begin
          n_bad++; $display("FAIL rnd_mis[%0d]: op=%s got req=%0d err=%0d done=%0d wr=%0d want 0 1 0 0",
            i, op.name(), obs_req_cycles, obs_err, obs_done, obs_wr); end
      end else begin
        n_cmp++; if (obs_addr !== {addr[31:2], 2'b00} || obs_be !== ref_be(op, addr) ||
                     obs_we !== is_store(op)) begin n_bad++;
          $display("FAIL rnd_bus[%0d]: op=%s got addr=%h be=%b we=%b want %h %b %b", i, op.name(),
            obs_addr, obs_be, obs_we, {addr[31:2], 2'b00}, ref_be(op, addr), is_store(op)); end
        n_cmp++; if (obs_wdata !== ref_store_data(op, wd) || !obs_stable ||
                     obs_req_cycles !== gd + 1) begin n_bad++;
          $display("FAIL rnd_wdata[%0d]: op=%s got %h stable=%b req=%0d want %h 1 %0d", i,
            op.name(), obs_wdata, obs_stable, obs_req_cycles, ref_store_data(op, wd), gd + 1); end
        n_cmp++; if (obs_done !== 1 || obs_err !== int'(berr) ||
                     obs_wr !== int'(!is_store(op) && !berr)) begin n_bad++;
          $display("FAIL rnd_resp[%0d]: op=%s got done=%0d err=%0d wr=%0d want 1 %0d %0d", i,
            op.name(), obs_done, obs_err, obs_wr, berr, !is_store(op) && !berr); end
        if (!is_store(op) && !berr) begin
          exp_ld = ref_load(op, addr, rdata);
          exp_hold = exp_ld;
          n_cmp++; if (obs_rdata !== exp_ld || obs_rd !== rd) begin n_bad++;
            $display("FAIL rnd_load[%0d]: op=%s addr=%h rdata=%h got %h rd=%0d want %h %0d", i,
              op.name(), addr, rdata, obs_rdata, obs_rd, exp_ld, rd); end
        end
      end
      n_cmp++; if (obs_hold !== exp_hold) begin n_bad++;
        $display("FAIL rnd_hold[%0d]: got %h want %h", i, obs_hold, exp_hold); end
    end
  endtask

  initial begin
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_op = LSU_NONE; lsu_addr = '0; lsu_wdata = '0; lsu_rd = '0;
    data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0; data_err = 1'b0;
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half_stall();
    test_misaligned();
    test_bus_error();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit for the milano RV32IM core. It accepts one memory operation per request from the ID-EX stage: the request, write enable, operation, effective address from the ALU, store data from rs2, and destination register. It drives the data-memory bus through a req/gnt/rvalid handshake. It returns sign- or zero-extended load data and a one-cycle register write-back pulse, and it holds busy so the pipeline stalls until the access completes.

Parameters:
MISALIGN_CHECK, 1, 1: a misaligned LH/LHU/SH/LW/SW raises lsu_err_o and issues no bus access. 0: address low bits are forced to natural alignment and the access proceeds.

Ports:
clk_i  input  1  core clock
rst_ni  input  1  asynchronous active-low reset
lsu_req_i  input  1  access request from ID-EX
lsu_we_i  input  1  1 = store, 0 = load
lsu_operate_i  input  milano_pkg::lsu_opt_e  LSU_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW
lsu_addr_i  input  32  effective byte address (rs1 + imm)
lsu_wdata_i  input  32  store data (rs2)
lsu_rd_addr_i  input  5  load destination register
lsu_busy_o  output  1  access in flight; pipeline must stall
lsu_rd_addr_o  output  5  write-back register address
lsu_rd_wr_en_o  output  1  one-cycle register write pulse
lsu_rdata_o  output  32  extended load data
lsu_done_o  output  1  one-cycle completion pulse (load or store)
lsu_err_o  output  1  one-cycle misaligned or bus-error pulse
data_req_o  output  1  bus request
data_gnt_i  input  1  bus grant
data_addr_o  output  32  word-aligned bus address
data_we_o  output  1  bus write enable
data_be_o  output  4  byte enables
data_wdata_o  output  32  lane-replicated store data
data_rvalid_i  input  1  response valid
data_rdata_i  input  32  response read data
data_err_i  input  1  response error, qualified by data_rvalid_i

Behaviour:
- Reset (async, rst_ni=0): state IDLE. All outputs 0 and all internal registers cleared. Any outstanding bus transaction is abandoned. rvalid is ignored until a new request is granted.
- FSM states:
  - IDLE:
    - Accept when lsu_req_i=1 and lsu_operate_i != LSU_NONE.
    - Latch operation, address, wdata and rd_addr on acceptance.
    - If misaligned and MISALIGN_CHECK=1, next cycle pulse lsu_err_o=1 and stay IDLE. No bus request, no register write.
    - Otherwise go to WAIT_GNT.
    - lsu_req_i with LSU_NONE is ignored.
  - WAIT_GNT:
    - data_req_o=1, with addr/we/be/wdata driven from the latched registers.
    - These signals are held stable until the cycle data_gnt_i=1, then go to WAIT_RVALID.
  - WAIT_RVALID:
    - data_req_o=0.
    - data_rvalid_i is sampled only in this state; the bus guarantees rvalid at least one cycle after gnt.
    - On rvalid with data_err_i=1: pulse lsu_err_o and lsu_done_o; no register write.
    - On rvalid with data_err_i=0: pulse lsu_done_o. For loads, also pulse lsu_rd_wr_en_o with lsu_rdata_o and lsu_rd_addr_o valid the same cycle. Store responses never write a register.
    - Then go to IDLE.
- lsu_busy_o = (state != IDLE), combinational.
- lsu_req_i is ignored while busy; the pipeline must hold the request stable until lsu_done_o.
- Minimum latency: accept at cycle 0, req at cycle 1, gnt at cycle 1, rvalid at cycle 2, writeback pulse at cycle 2. The next request can be accepted at cycle 3.
- Misalignment definitions:
  - halfword: addr[0]!=0.
  - word: addr[1:0]!=0.
  - Byte accesses are never misaligned.
- Bus signal formation:
  - data_addr_o = {addr[31:2], 2'b00}.
  - Byte access: data_be_o = 4'b0001 << addr[1:0].
  - Halfword access: data_be_o = 4'b0011 << {addr[1], 1'b0}.
  - Word access: data_be_o = 4'b1111.
  - Loads use the same byte enables.
- Store data:
  - SB: data_wdata_o = {4{wdata[7:0]}}.
  - SH: data_wdata_o = {2{wdata[15:0]}}.
  - SW: data_wdata_o = wdata.
  - Loads: data_wdata_o = 0.
- Load data:
  - Shift data_rdata_i right by 8*addr[1:0], then extract.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- lsu_rdata_o holds its last value between pulses. lsu_rd_wr_en_o, lsu_done_o and lsu_err_o are exactly one cycle wide.

Test Plan:
- LW addr=0x100; gnt immediately, rvalid next cycle with rdata=0xDEADBEEF -> data_addr_o=0x100, be=1111; lsu_rdata_o=0xDEADBEEF with lsu_rd_wr_en_o=1 for one cycle; busy high for 2 cycles.
- LB addr=0x203, rdata=0x80112233 -> be=1000, lsu_rdata_o=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH addr=0x302, wdata=0x0000ABCD; gnt held low 3 cycles -> req/addr=0x300/be=1100/wdata=0xABCDABCD stable throughout; lsu_done_o pulses on rvalid; lsu_rd_wr_en_o never asserted.
- LW addr=0x101 with MISALIGN_CHECK=1 -> data_req_o never asserted, lsu_err_o one-cycle pulse, no register write, busy low.
- LH addr=0x400; rvalid with data_err_i=1 -> lsu_err_o and lsu_done_o pulse, lsu_rd_wr_en_o=0.
- rst_ni deasserted while in WAIT_RVALID, then a late rvalid arrives -> all outputs 0, state IDLE, late rvalid produces no pulse; a following SB completes normally.
